// File: rtl/riscv_mdu_pkg.sv
// riscv_mdu_pkg: op encodings, FSM states and the conditional
// negate helper shared by the multiply/divide unit.
package riscv_mdu_pkg;

    localparam int MAXW = 128;

    localparam logic [3:0] OP_MUL    = 4'b0000;
    localparam logic [3:0] OP_MULH   = 4'b0001;
    localparam logic [3:0] OP_MULHSU = 4'b0010;
    localparam logic [3:0] OP_MULHU  = 4'b0011;
    localparam logic [3:0] OP_DIV    = 4'b0100;
    localparam logic [3:0] OP_DIVU   = 4'b0101;
    localparam logic [3:0] OP_REM    = 4'b0110;
    localparam logic [3:0] OP_REMU   = 4'b0111;
    localparam logic [3:0] OP_MULW   = 4'b1000;
    localparam logic [3:0] OP_DIVW   = 4'b1100;
    localparam logic [3:0] OP_DIVUW  = 4'b1101;
    localparam logic [3:0] OP_REMW   = 4'b1110;
    localparam logic [3:0] OP_REMUW  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        DONE
    } state_t;

    // Width-generic: callers zero-extend into MAXW and keep the low bits.
    function automatic logic [MAXW-1:0] cond_neg(
        input logic [MAXW-1:0] v,
        input logic            neg
    );
        return neg ? (~v + MAXW'(1)) : v;
    endfunction

endpackage

// File: rtl/riscv_mdu_sign_fix.sv
// riscv_mdu_sign_fix: sign restore, result field select and
// word sign-extension for the final and fast-path results.
module riscv_mdu_sign_fix
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic [3:0]        op,
    input  logic [2*XLEN-1:0] prod,
    input  logic [XLEN-1:0]   quo,
    input  logic [XLEN-1:0]   rem,
    input  logic              neg_p,
    input  logic              neg_q,
    input  logic              neg_r,
    output logic [XLEN-1:0]   result
);

    logic [MAXW-1:0]   p_full;
    logic [MAXW-1:0]   q_full;
    logic [MAXW-1:0]   r_full;
    logic [2*XLEN-1:0] p_fix;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [XLEN-1:0]   sel;
    logic              is_mul_lo;
    logic              is_mul_hi;
    logic              is_quo;
    logic              is_rem;

    assign p_full = cond_neg(MAXW'(prod), neg_p);
    assign q_full = cond_neg(MAXW'(quo), neg_q);
    assign r_full = cond_neg(MAXW'(rem), neg_r);

    assign p_fix = p_full[2*XLEN-1:0];
    assign q_fix = q_full[XLEN-1:0];
    assign r_fix = r_full[XLEN-1:0];

    assign is_mul_lo = (op[2:0] == OP_MUL[2:0]);
    assign is_mul_hi = !op[2] && !is_mul_lo;
    assign is_quo    = op[2] && !op[1];
    assign is_rem    = op[2] && op[1];

    always_comb begin
        sel = '0;
        unique case (1'b1)
            is_mul_lo: sel = p_fix[XLEN-1:0];
            is_mul_hi: sel = p_fix[2*XLEN-1:XLEN];
            is_quo:    sel = q_fix;
            is_rem:    sel = r_fix;
            default:   sel = '0;
        endcase
    end

    generate
        if (XLEN > 32 && WORD_OPS != 0) begin : g_word
            logic [XLEN-1:0] sel_sx;
            assign sel_sx = {{(XLEN-32){sel[31]}}, sel[31:0]};
            assign result = op[3] ? sel_sx : sel;
        end else begin : g_noword
            assign result = sel;
        end
    endgenerate

endmodule

// File: rtl/riscv_mdu.sv
// riscv_mdu: iterative radix-2 RV64M/RV32M multiply/divide unit
// with a single-cycle path for divide special cases.
module riscv_mdu
    import riscv_mdu_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int WORD_OPS = 1
) (
    input  logic            i_riscv_mdu_clk,
    input  logic            i_riscv_mdu_rst_n,
    input  logic            i_riscv_mdu_start,
    input  logic [3:0]      i_riscv_mdu_ctrl,
    input  logic [XLEN-1:0] i_riscv_mdu_rs1data,
    input  logic [XLEN-1:0] i_riscv_mdu_rs2data,
    input  logic            i_riscv_mdu_kill,
    output logic            o_riscv_mdu_ready,
    output logic            o_riscv_mdu_busy,
    output logic            o_riscv_mdu_valid,
    output logic [XLEN-1:0] o_riscv_mdu_result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        op_q;
    logic              sa_q;
    logic              sb_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mc_q;
    logic [CW-1:0]     cnt_q;

    logic              word;
    logic [2:0]        f3;
    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              illegal;
    logic              b_zero;
    logic              ovf;
    logic              fast;
    logic              accept;
    logic              sa_in;
    logic              sb_in;
    logic [XLEN-1:0]   a_sx;
    logic [XLEN-1:0]   a_zx;
    logic [XLEN-1:0]   b_sx;
    logic [XLEN-1:0]   b_zx;
    logic [XLEN-1:0]   a_w;
    logic [XLEN-1:0]   b_w;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [CW-1:0]     iter;

    assign word   = i_riscv_mdu_ctrl[3];
    assign f3     = i_riscv_mdu_ctrl[2:0];
    assign is_div = f3[2];
    assign sgn_a  = !(f3 == 3'b011 || f3 == 3'b101 || f3 == 3'b111);
    assign sgn_b  = sgn_a && (f3 != 3'b010);
    assign illegal = word && ((WORD_OPS == 0) || (!f3[2] && f3 != 3'b000));

    generate
        if (XLEN > 32) begin : g_ext
            assign a_sx = {{(XLEN-32){i_riscv_mdu_rs1data[31]}}, i_riscv_mdu_rs1data[31:0]};
            assign a_zx = {{(XLEN-32){1'b0}}, i_riscv_mdu_rs1data[31:0]};
            assign b_sx = {{(XLEN-32){i_riscv_mdu_rs2data[31]}}, i_riscv_mdu_rs2data[31:0]};
            assign b_zx = {{(XLEN-32){1'b0}}, i_riscv_mdu_rs2data[31:0]};
        end else begin : g_noext
            assign a_sx = i_riscv_mdu_rs1data;
            assign a_zx = i_riscv_mdu_rs1data;
            assign b_sx = i_riscv_mdu_rs2data;
            assign b_zx = i_riscv_mdu_rs2data;
        end
    endgenerate

    assign a_w   = word ? (sgn_a ? a_sx : a_zx) : i_riscv_mdu_rs1data;
    assign b_w   = word ? (sgn_b ? b_sx : b_zx) : i_riscv_mdu_rs2data;
    assign sa_in = sgn_a && a_w[XLEN-1];
    assign sb_in = sgn_b && b_w[XLEN-1];
    assign a_mag = sa_in ? (~a_w + 1'b1) : a_w;
    assign b_mag = sb_in ? (~b_w + 1'b1) : b_w;
    assign iter  = word ? CW'(32) : CW'(XLEN);

    assign b_zero = word ? (i_riscv_mdu_rs2data[31:0] == 32'd0)
                         : (i_riscv_mdu_rs2data == '0);
    assign ovf = is_div && !f3[0] &&
                 (word ? (i_riscv_mdu_rs1data[31:0] == 32'h8000_0000 &&
                          i_riscv_mdu_rs2data[31:0] == 32'hFFFF_FFFF)
                       : (i_riscv_mdu_rs1data == MIN_X &&
                          i_riscv_mdu_rs2data == {XLEN{1'b1}}));
    assign fast   = illegal || (is_div && (b_zero || ovf));
    assign accept = (state_q == IDLE) && i_riscv_mdu_start && !i_riscv_mdu_kill;

    // one radix-2 step; the dividend MSB sits at bit 31 for word ops
    logic              msb;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;
    logic              ge;
    logic [2*XLEN-1:0] prod_nx;

    assign msb     = op_q[3] ? a_q[31] : a_q[XLEN-1];
    assign r_sh    = {acc_q[XLEN-1:0], msb};
    assign diff    = r_sh - {1'b0, b_q};
    assign ge      = !diff[XLEN];
    assign prod_nx = acc_q + (b_q[0] ? mc_q : '0);

    logic [3:0]        fx_op;
    logic [2*XLEN-1:0] fx_prod;
    logic [XLEN-1:0]   fx_quo;
    logic [XLEN-1:0]   fx_rem;
    logic              fx_np;
    logic              fx_nq;
    logic              fx_nr;
    logic [XLEN-1:0]   fix_res;

    // IDLE feeds the fast-path values, otherwise the iteration result
    always_comb begin
        fx_op   = op_q;
        fx_prod = acc_q;
        fx_quo  = a_q;
        fx_rem  = acc_q[XLEN-1:0];
        fx_np   = sa_q ^ sb_q;
        fx_nq   = sa_q ^ sb_q;
        fx_nr   = sa_q;
        if (state_q == IDLE) begin
            fx_op   = i_riscv_mdu_ctrl;
            fx_prod = '0;
            fx_quo  = illegal ? '0 : (b_zero ? '1 : i_riscv_mdu_rs1data);
            fx_rem  = (!illegal && b_zero) ? i_riscv_mdu_rs1data : '0;
            fx_np   = 1'b0;
            fx_nq   = 1'b0;
            fx_nr   = 1'b0;
        end
    end

    riscv_mdu_sign_fix #(
        .XLEN     (XLEN),
        .WORD_OPS (WORD_OPS)
    ) u_sign_fix (
        .op     (fx_op),
        .prod   (fx_prod),
        .quo    (fx_quo),
        .rem    (fx_rem),
        .neg_p  (fx_np),
        .neg_q  (fx_nq),
        .neg_r  (fx_nr),
        .result (fix_res)
    );

    always_ff @(posedge i_riscv_mdu_clk or negedge i_riscv_mdu_rst_n) begin
        if (!i_riscv_mdu_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (i_riscv_mdu_kill) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (i_riscv_mdu_start) state_d = fast ? DONE : CALC;
                CALC:  if (cnt_q == CW'(1)) state_d = FIXUP;
                FIXUP: state_d = DONE;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_riscv_mdu_clk or negedge i_riscv_mdu_rst_n) begin
        if (!i_riscv_mdu_rst_n) begin
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= i_riscv_mdu_ctrl;
            sa_q  <= sa_in;
            sb_q  <= sb_in;
            a_q   <= a_mag;
            b_q   <= b_mag;
            acc_q <= '0;
            mc_q  <= {{XLEN{1'b0}}, a_mag};
            cnt_q <= iter;
            if (fast) result_q <= fix_res;
        end else if (!i_riscv_mdu_kill && state_q == CALC) begin
            cnt_q <= cnt_q - 1'b1;
            if (op_q[2]) begin
                acc_q <= {{XLEN{1'b0}}, (ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0])};
                a_q   <= {a_q[XLEN-2:0], ge};
            end else begin
                acc_q <= prod_nx;
                mc_q  <= mc_q << 1;
                b_q   <= b_q >> 1;
            end
        end else if (!i_riscv_mdu_kill && state_q == FIXUP) begin
            result_q <= fix_res;
        end
    end

    assign o_riscv_mdu_ready  = (state_q == IDLE);
    assign o_riscv_mdu_busy   = (state_q == CALC) || (state_q == FIXUP);
    assign o_riscv_mdu_valid  = (state_q == DONE);
    assign o_riscv_mdu_result = result_q;

endmodule

// File: tb/tb_riscv_mdu.sv
// tb_riscv_mdu: randomized and directed checks of riscv_mdu (XLEN=64)
// against an arithmetic reference model.
module tb_riscv_mdu;

    localparam logic [3:0] MUL    = 4'd0;
    localparam logic [3:0] MULH   = 4'd1;
    localparam logic [3:0] MULHSU = 4'd2;
    localparam logic [3:0] MULHU  = 4'd3;
    localparam logic [3:0] DIV    = 4'd4;
    localparam logic [3:0] DIVU   = 4'd5;
    localparam logic [3:0] REM    = 4'd6;
    localparam logic [3:0] MULW   = 4'd8;
    localparam logic [3:0] DIVW   = 4'd12;
    localparam logic [3:0] REMW   = 4'd14;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        kill;
    logic [3:0]  ctrl;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [63:0] result;

    int pass_cnt;
    int total_cnt;

    riscv_mdu #(
        .XLEN     (64),
        .WORD_OPS (1)
    ) dut (
        .i_riscv_mdu_clk     (clk),
        .i_riscv_mdu_rst_n   (rst_n),
        .i_riscv_mdu_start   (start),
        .i_riscv_mdu_ctrl    (ctrl),
        .i_riscv_mdu_rs1data (rs1),
        .i_riscv_mdu_rs2data (rs2),
        .i_riscv_mdu_kill    (kill),
        .o_riscv_mdu_ready   (ready),
        .o_riscv_mdu_busy    (busy),
        .o_riscv_mdu_valid   (valid),
        .o_riscv_mdu_result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_fast(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [2:0] f;
        f = op[2:0];
        if (op[3] && f != 3'd0 && !f[2]) return 1'b1;
        if (!f[2]) return 1'b0;
        if (op[3]) begin
            if (b[31:0] == 32'd0) return 1'b1;
            return !f[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF;
        end
        if (b == 64'd0) return 1'b1;
        return !f[0] && a == MIN64 && b == '1;
    endfunction

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [2:0]         f;
        logic [127:0]       ea;
        logic [127:0]       eb;
        logic [127:0]       p;
        logic signed [63:0] sa64;
        logic signed [63:0] sb64;
        logic signed [63:0] r64s;
        logic signed [31:0] sa32;
        logic signed [31:0] sb32;
        logic signed [31:0] r32s;
        logic [31:0]        r32;
        f = op[2:0];
        if (!op[3]) begin
            ea = (f == 3'd3) ? {64'd0, a} : {{64{a[63]}}, a};
            eb = (f == 3'd2 || f == 3'd3) ? {64'd0, b} : {{64{b[63]}}, b};
            p = ea * eb;
            sa64 = a;
            sb64 = b;
            case (f)
                3'd0: return p[63:0];
                3'd1, 3'd2, 3'd3: return p[127:64];
                3'd4: begin
                    if (b == 0) return '1;
                    if (a == MIN64 && b == '1) return a;
                    r64s = sa64 / sb64;
                    return r64s;
                end
                3'd5: begin
                    if (b == 0) return '1;
                    return a / b;
                end
                3'd6: begin
                    if (b == 0) return a;
                    if (a == MIN64 && b == '1) return 64'd0;
                    r64s = sa64 % sb64;
                    return r64s;
                end
                default: begin
                    if (b == 0) return a;
                    return a % b;
                end
            endcase
        end
        sa32 = a[31:0];
        sb32 = b[31:0];
        r32 = 32'd0;
        case (f)
            3'd0: r32 = a[31:0] * b[31:0];
            3'd4: begin
                if (b[31:0] == 0) r32 = '1;
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = a[31:0];
                else begin r32s = sa32 / sb32; r32 = r32s; end
            end
            3'd5: r32 = (b[31:0] == 0) ? '1 : a[31:0] / b[31:0];
            3'd6: begin
                if (b[31:0] == 0) r32 = a[31:0];
                else if (a[31:0] == 32'h8000_0000 && b[31:0] == '1) r32 = 32'd0;
                else begin r32s = sa32 % sb32; r32 = r32s; end
            end
            3'd7: r32 = (b[31:0] == 0) ? a[31:0] : a[31:0] % b[31:0];
            default: r32 = 32'd0;
        endcase
        return {{32{r32[31]}}, r32};
    endfunction

    // lat counts posedges from the accept edge (inclusive) up to the
    // edge after which valid is seen; -1 if it never arrives
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat, output bit rdy_seen);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        ctrl = op;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        rdy_seen = 1'b0;
        @(negedge clk);
        while (!valid && lat < 300) begin
            if (ready) rdy_seen = 1'b1;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = result;
        if (!valid) lat = -1;
    endtask

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return '1;
            2: return MIN64;
            3: return 64'h0000_0000_8000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        kill = 1'b0;
        ctrl = 4'd0;
        rs1 = 64'd0;
        rs2 = 64'd0;
        #2;
        total_cnt++;
        if ({ready, busy, valid} !== 3'b100) $display("FAIL reset_flags got=%b want=100", {ready, busy, valid});
        else pass_cnt++;
        total_cnt++;
        if (result !== 64'd0) $display("FAIL reset_result got=%h want=0", result);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({ready, busy, valid} !== 3'b100) $display("FAIL post_reset_flags got=%b want=100", {ready, busy, valid});
        else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [3:0]  ops [12] = '{MUL, MULHU, MULH, MULHSU, DIV, REM, DIVU, DIVW,
                                  DIVU, REM, DIV, REMW};
        logic [63:0] as [12] = '{64'd7, '1, '1, '1, -64'sd20, -64'sd20, 64'd20,
                                 64'h0000_0000_8000_0000, 64'd123, 64'd5, MIN64,
                                 64'h0000_0000_8000_0000};
        logic [63:0] bs [12] = '{-64'sd3, '1, '1, 64'd2, 64'd3, 64'd3, 64'd3, 64'd1,
                                 64'd0, 64'd0, '1, '1};
        logic [63:0] ex [12] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0,
                                 '1, -64'sd6, -64'sd2, 64'd6, 64'hFFFF_FFFF_8000_0000,
                                 '1, 64'd5, MIN64, 64'd0};
        int          el [12] = '{66, 66, 66, 66, 66, 66, 66, 34, 1, 1, 1, 1};
        logic [63:0] res;
        int          lat;
        bit          rs;
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i], res, lat, rs);
            total_cnt++;
            if (res !== ex[i]) $display("FAIL dir%0d_result got=%h want=%h", i, res, ex[i]);
            else pass_cnt++;
            total_cnt++;
            if (lat != el[i]) $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, el[i]);
            else pass_cnt++;
            if (i == 0) begin
                total_cnt++;
                if (rs !== 1'b0) $display("FAIL dir0_ready_low got=%b want=0", rs);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
        logic [63:0] exp_r;
        int          lat;
        int          exp_l;
        bit          rs;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a = rnd_operand();
            b = rnd_operand();
            exp_r = ref_result(op, a, b);
            exp_l = ref_fast(op, a, b) ? 1 : (op[3] ? 34 : 66);
            issue(op, a, b, res, lat, rs);
            total_cnt++;
            if (res !== exp_r) $display("FAIL rnd%0d_op%0d got=%h want=%h", i, op, res, exp_r);
            else pass_cnt++;
            total_cnt++;
            if (lat != exp_l) $display("FAIL rnd%0d_latency got=%0d want=%0d", i, lat, exp_l);
            else pass_cnt++;
        end
    endtask

    task automatic test_kill();
        logic [63:0] prev;
        int          lat;
        int          n;
        bit          rs;
        bit          seen;
        issue(DIVU, 64'd20, 64'd3, prev, lat, rs);
        total_cnt++;
        if (prev !== 64'd6) $display("FAIL kill_setup got=%h want=6", prev);
        else pass_cnt++;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        ctrl = DIV;
        rs1 = -64'sd100;
        rs2 = 64'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL kill_busy_before got=%b want=1", busy);
        else pass_cnt++;
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (ready !== 1'b1) $display("FAIL kill_ready got=%b want=1", ready);
        else pass_cnt++;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL kill_no_valid got=%b want=0", seen);
        else pass_cnt++;
        total_cnt++;
        if (result !== prev) $display("FAIL kill_result_held got=%h want=%h", result, prev);
        else pass_cnt++;
        ctrl = DIVU;
        rs1 = 64'd9;
        rs2 = 64'd0;
        start = 1'b1;
        kill = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        kill = 1'b0;
        @(negedge clk);
        total_cnt++;
        if ({ready, valid} !== 2'b10) $display("FAIL kill_beats_start got=%b want=10", {ready, valid});
        else pass_cnt++;
        total_cnt++;
        if (result !== prev) $display("FAIL kill_start_result got=%h want=%h", result, prev);
        else pass_cnt++;
    endtask

    task automatic test_start_ignored();
        logic [63:0] exp_r;
        int          lat;
        int          n;
        bit          seen;
        exp_r = ref_result(DIV, -64'sd20, 64'd3);
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        ctrl = DIV;
        rs1 = -64'sd20;
        rs2 = 64'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        repeat (5) begin
            @(posedge clk);
            lat++;
        end
        #1;
        ctrl = MUL;
        rs1 = 64'd1;
        rs2 = 64'd1;
        start = 1'b1;
        @(posedge clk);
        lat++;
        #1 start = 1'b0;
        @(negedge clk);
        while (!valid && lat < 300) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        total_cnt++;
        if (result !== exp_r || !valid) $display("FAIL ignored_start_result got=%h want=%h", result, exp_r);
        else pass_cnt++;
        total_cnt++;
        if (lat != 66) $display("FAIL ignored_start_latency got=%0d want=66", lat);
        else pass_cnt++;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (valid) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL ignored_start_queued got=%b want=0", seen);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        logic [63:0] exp_r;
        int          lat;
        int          n;
        bit          rs;
        n = 0;
        while (!ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        ctrl = MUL;
        rs1 = 64'd12345;
        rs2 = 64'd678;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({ready, busy, valid} !== 3'b100) $display("FAIL arst_flags got=%b want=100", {ready, busy, valid});
        else pass_cnt++;
        total_cnt++;
        if (result !== 64'd0) $display("FAIL arst_result got=%h want=0", result);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_r = ref_result(MULW, 64'h0000_0000_7FFF_FFFF, 64'd2);
        issue(MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, res, lat, rs);
        total_cnt++;
        if (res !== exp_r) $display("FAIL arst_mulw got=%h want=%h", res, exp_r);
        else pass_cnt++;
        total_cnt++;
        if (lat != 34) $display("FAIL arst_mulw_latency got=%0d want=34", lat);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_directed();
        test_random();
        test_kill();
        test_start_ignored();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
